// File: rtl/fifo_burst_pkg.sv
// fifo_burst_pkg
//   Shared types for the FIFO burst reader. Holds the FSM state encoding so
//   the top and the testbench agree on the state names.
package fifo_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } fifo_burst_state_e;

endpackage : fifo_burst_pkg

// File: rtl/burst_out_buffer.sv
// burst_out_buffer
//   Two-entry in-order valid/ready queue carrying {payload, last}. It sits
//   between the FIFO pop strobe and the consumer, so consumer back-pressure
//   never reaches the pop logic combinationally.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous active-high reset (clears count and storage)
//   clr_i        synchronous clear, same effect as reset
//   push_i       write {push_data_i, push_last_i} at the tail
//   push_data_i  payload to write
//   push_last_i  last flag to write
//   pop_i        consumer accepted the head this cycle
//   valid_o      queue not empty
//   data_o       head payload
//   last_o       head last flag
//   cnt_o        occupancy, 0..2
module burst_out_buffer #(
    parameter type dtype = logic [31:0]
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       push_i,
    input  dtype       push_data_i,
    input  logic       push_last_i,
    input  logic       pop_i,
    output logic       valid_o,
    output dtype       data_o,
    output logic       last_o,
    output logic [1:0] cnt_o
);

    typedef struct packed {
        dtype data;
        logic last;
    } entry_t;

    entry_t     head_q;
    entry_t     tail_q;
    entry_t     new_ent;
    logic [1:0] cnt_q;
    logic       do_push;
    logic       do_pop;

    assign new_ent = '{data: push_data_i, last: push_last_i};

    // A pop of an empty queue is ignored; a push into a full queue is only
    // taken when the head leaves in the same cycle.
    assign do_pop  = pop_i & (cnt_q != 2'd0);
    assign do_push = push_i & ((cnt_q != 2'd2) | do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= new_ent;
                    else               tail_q <= new_ent;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; shift and refill.
                    if (cnt_q == 2'd1) begin
                        head_q <= new_ent;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= new_ent;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = head_q.data;
    assign last_o  = head_q.last;
    assign cnt_o   = cnt_q;

endmodule : burst_out_buffer

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-side engine for a push/pop FIFO. Accepts a burst command of
//   cmd_len_i+1 beats, pops exactly that many words from the FIFO and
//   streams them out on valid/ready, flagging the final beat with last.
//   A 2-entry output buffer decouples the consumer from the pop strobe.
//
// Ports
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   flush_i       synchronous abort: drop burst in flight, clear buffer
//   cmd_valid_i   burst command valid
//   cmd_ready_o   command accepted on cmd_valid_i & cmd_ready_o
//   cmd_len_i     beats minus one
//   fifo_empty_i  FIFO empty flag
//   fifo_data_i   FIFO head data
//   fifo_pop_o    pop FIFO head this cycle
//   out_valid_o   output beat valid
//   out_ready_i   consumer ready
//   out_data_o    output payload
//   out_last_o    final beat of burst
//   busy_o        burst in progress
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter type dtype      = logic [DATA_WIDTH-1:0],
    parameter int  LEN_WIDTH  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [LEN_WIDTH-1:0] cmd_len_i,
    input  logic                 fifo_empty_i,
    input  dtype                 fifo_data_i,
    output logic                 fifo_pop_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output dtype                 out_data_o,
    output logic                 out_last_o,
    output logic                 busy_o
);

    fifo_burst_state_e    state_q;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic [1:0]           buf_cnt;
    logic                 buf_pop;
    logic                 abort;

    assign abort = rst_i | flush_i;

    // Pop depends only on state, FIFO flag and buffer room -- never on
    // out_ready_i -- and is suppressed in a reset/flush cycle so no word is
    // removed from the FIFO only to be thrown away.
    assign fifo_pop_o = (state_q == BURST) & ~fifo_empty_i &
                        (buf_cnt != 2'd2) & ~abort;

    assign buf_pop = out_valid_o & out_ready_i;

    // A command offered in a flush cycle would be lost because the flush
    // forces IDLE, so ready is withheld for that one cycle.
    assign cmd_ready_o = (state_q == IDLE) & ~flush_i;
    assign busy_o      = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (abort) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        remaining_q <= cmd_len_i;
                        state_q     <= BURST;
                    end
                end
                BURST: begin
                    // Counter stops at zero; the zero-count pop carries last.
                    if (fifo_pop_o) begin
                        if (remaining_q == '0) state_q <= DRAIN;
                        else                   remaining_q <= remaining_q - 1'b1;
                    end
                end
                DRAIN: begin
                    if (buf_pop && out_last_o) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    burst_out_buffer #(
        .dtype (dtype)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (flush_i),
        .push_i      (fifo_pop_o),
        .push_data_i (fifo_data_i),
        .push_last_i (remaining_q == '0),
        .pop_i       (buf_pop),
        .valid_o     (out_valid_o),
        .data_o      (out_data_o),
        .last_o      (out_last_o),
        .cnt_o       (buf_cnt)
    );

endmodule : fifo_burst_reader

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader
//   Directed bench for fifo_burst_reader. A queue models the FIFO; outputs
//   are sampled on the falling edge, inputs change 1 time unit after the
//   rising edge.
module tb_fifo_burst_reader;

    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_i, flush_i, cmd_valid_i, cmd_ready_o;
    logic [LW-1:0] cmd_len_i;
    logic          fifo_empty_i, fifo_pop_o;
    logic [DW-1:0] fifo_data_i;
    logic          out_valid_o, out_ready_i, out_last_o, busy_o;
    logic [DW-1:0] out_data_o;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] fq[$];
    bit            force_empty = 1'b0;

    logic          s_pop, s_valid, s_last, s_crdy, s_busy, s_ready;
    logic [DW-1:0] s_data;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_len_i    (cmd_len_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_pop_o   (fifo_pop_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o)
    );

    task automatic drive_fifo();
        fifo_empty_i = force_empty || (fq.size() == 0);
        fifo_data_i  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    // One clock cycle: sample outputs, let the edge happen, retire a popped word.
    task automatic tick();
        @(negedge clk);
        s_pop = fifo_pop_o; s_valid = out_valid_o; s_last = out_last_o;
        s_crdy = cmd_ready_o; s_busy = busy_o; s_data = out_data_o; s_ready = out_ready_i;
        @(posedge clk);
        #1;
        if (s_pop === 1'b1 && fq.size() != 0) fq.delete(0);
        drive_fifo();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; cmd_valid_i = 1'b0; cmd_len_i = '0; out_ready_i = 1'b1;
        fq.delete(); fq.push_back(32'hAA); drive_fifo();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (s_crdy !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", s_crdy); end
            checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", s_busy); end
            checks++; if (s_pop !== 1'b0) begin failures++; $display("FAIL rst_pop got=%b exp=0", s_pop); end
            checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", s_valid); end
            checks++; if (s_last !== 1'b0) begin failures++; $display("FAIL rst_last got=%b exp=0", s_last); end
            checks++; if (s_data !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", s_data); end
        end
        rst_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (s_crdy !== 1'b1) begin failures++; $display("FAIL idle_cmd_ready c=%0d got=%b exp=1", c, s_crdy); end
            checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL idle_busy c=%0d got=%b exp=0", c, s_busy); end
            checks++; if (s_pop !== 1'b0) begin failures++; $display("FAIL idle_pop c=%0d got=%b exp=0", c, s_pop); end
            checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL idle_valid c=%0d got=%b exp=0", c, s_valid); end
        end
        fq.delete(); drive_fifo();
    endtask

    task automatic test_burst8();
        logic exp_pop, exp_vld;
        for (int i = 0; i < 8; i++) fq.push_back(DW'(32'h10 + i));
        drive_fifo();
        out_ready_i = 1'b1; cmd_len_i = 8'd7; cmd_valid_i = 1'b1;
        tick();
        checks++; if (s_crdy !== 1'b1) begin failures++; $display("FAIL b8_cmd_ready_c0 got=%b exp=1", s_crdy); end
        cmd_valid_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            exp_pop = (c <= 8);
            exp_vld = (c >= 2 && c <= 9);
            checks++; if (s_pop !== exp_pop) begin failures++; $display("FAIL b8_pop c=%0d got=%b exp=%b", c, s_pop, exp_pop); end
            checks++; if (s_valid !== exp_vld) begin failures++; $display("FAIL b8_valid c=%0d got=%b exp=%b", c, s_valid, exp_vld); end
            if (exp_vld) begin
                checks++; if (s_data !== DW'(32'h10 + c - 2)) begin failures++; $display("FAIL b8_data c=%0d got=%h exp=%h", c, s_data, 32'h10 + c - 2); end
                checks++; if (s_last !== (c == 9)) begin failures++; $display("FAIL b8_last c=%0d got=%b exp=%b", c, s_last, c == 9); end
            end
            checks++; if (s_crdy !== (c == 10)) begin failures++; $display("FAIL b8_cmd_ready c=%0d got=%b exp=%b", c, s_crdy, c == 10); end
        end
        fq.delete(); drive_fifo();
    endtask

    task automatic test_backpressure();
        bit            pat [4];
        int            mcnt, pops, beats, c;
        logic          held_v, held_l;
        logic [DW-1:0] held_d;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        mcnt = 0; pops = 0; beats = 0; held_v = 1'b0; held_l = 1'b0; held_d = '0;
        for (int i = 0; i < 9; i++) fq.push_back(DW'(32'h30 + i));
        drive_fifo();
        cmd_len_i = 8'd7; cmd_valid_i = 1'b1; out_ready_i = pat[0];
        tick();
        cmd_valid_i = 1'b0;
        c = 1;
        while (beats < 8 && c < 100) begin
            out_ready_i = pat[c % 4];
            tick();
            checks++; if (s_valid !== (mcnt != 0)) begin failures++; $display("FAIL bp_valid c=%0d got=%b exp=%b", c, s_valid, mcnt != 0); end
            if (mcnt == 2) begin
                checks++; if (s_pop !== 1'b0) begin failures++; $display("FAIL bp_pop_full c=%0d got=%b exp=0", c, s_pop); end
            end
            if (held_v) begin
                checks++; if (s_valid !== 1'b1 || s_data !== held_d || s_last !== held_l) begin
                    failures++; $display("FAIL bp_hold c=%0d got=%b/%h/%b exp=1/%h/%b", c, s_valid, s_data, s_last, held_d, held_l);
                end
            end
            if (s_valid === 1'b1 && s_ready === 1'b1) begin
                checks++; if (s_data !== DW'(32'h30 + beats)) begin failures++; $display("FAIL bp_data beat=%0d got=%h exp=%h", beats, s_data, 32'h30 + beats); end
                checks++; if (s_last !== (beats == 7)) begin failures++; $display("FAIL bp_last beat=%0d got=%b exp=%b", beats, s_last, beats == 7); end
                beats++;
                mcnt--;
            end
            held_v = (s_valid === 1'b1) && (s_ready !== 1'b1);
            held_d = s_data; held_l = s_last;
            if (s_pop === 1'b1) begin mcnt++; pops++; end
            c++;
        end
        checks++; if (beats != 8) begin failures++; $display("FAIL bp_beats got=%0d exp=8", beats); end
        out_ready_i = 1'b1;
        repeat (3) begin tick(); if (s_pop === 1'b1) pops++; end
        checks++; if (pops != 8) begin failures++; $display("FAIL bp_pops got=%0d exp=8", pops); end
        checks++; if (fq.size() != 1) begin failures++; $display("FAIL bp_fifo_left got=%0d exp=1", fq.size()); end
        fq.delete(); drive_fifo();
    endtask

    task automatic test_empty_stall();
        fq.push_back(32'h55); force_empty = 1'b1; drive_fifo();
        cmd_len_i = 8'd0; cmd_valid_i = 1'b1; out_ready_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++; if (s_pop !== 1'b0) begin failures++; $display("FAIL es_pop c=%0d got=%b exp=0", c, s_pop); end
            checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL es_valid c=%0d got=%b exp=0", c, s_valid); end
        end
        force_empty = 1'b0; drive_fifo();
        tick();
        checks++; if (s_pop !== 1'b1) begin failures++; $display("FAIL es_pop_c6 got=%b exp=1", s_pop); end
        tick();
        checks++; if (s_pop !== 1'b0) begin failures++; $display("FAIL es_pop_c7 got=%b exp=0", s_pop); end
        checks++; if (s_valid !== 1'b1 || s_data !== 32'h55 || s_last !== 1'b1) begin
            failures++; $display("FAIL es_beat got=%b/%h/%b exp=1/00000055/1", s_valid, s_data, s_last);
        end
        tick();
        checks++; if (s_crdy !== 1'b1 || s_busy !== 1'b0 || s_valid !== 1'b0) begin
            failures++; $display("FAIL es_idle got=%b/%b/%b exp=1/0/0", s_crdy, s_busy, s_valid);
        end
        fq.delete(); drive_fifo();
    endtask

    task automatic test_max_burst();
        int pops, beats, c;
        pops = 0; beats = 0; c = 0;
        for (int i = 0; i < 260; i++) fq.push_back(DW'(32'h1000 + i));
        drive_fifo();
        cmd_len_i = 8'd255; cmd_valid_i = 1'b1; out_ready_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        while (beats < 256 && c < 400) begin
            tick();
            if (s_pop === 1'b1) pops++;
            if (s_valid === 1'b1) begin
                checks++; if (s_data !== DW'(32'h1000 + beats) || s_last !== (beats == 255)) begin
                    failures++; $display("FAIL max_beat n=%0d got=%h/%b exp=%h/%b", beats, s_data, s_last, 32'h1000 + beats, beats == 255);
                end
                beats++;
            end
            c++;
        end
        checks++; if (beats != 256) begin failures++; $display("FAIL max_beats got=%0d exp=256", beats); end
        tick();
        if (s_pop === 1'b1) pops++;
        checks++; if (s_crdy !== 1'b1) begin failures++; $display("FAIL max_cmd_ready got=%b exp=1", s_crdy); end
        repeat (3) begin tick(); if (s_pop === 1'b1) pops++; end
        checks++; if (pops != 256) begin failures++; $display("FAIL max_pops got=%0d exp=256", pops); end
        checks++; if (fq.size() != 4) begin failures++; $display("FAIL max_fifo_left got=%0d exp=4", fq.size()); end
        fq.delete(); drive_fifo();
    endtask

    task automatic test_flush();
        int pops, beats;
        for (int i = 0; i < 8; i++) fq.push_back(DW'(32'h20 + i));
        drive_fifo();
        // 6-beat burst: three pops, one beat consumed, two left buffered.
        cmd_len_i = 8'd5; cmd_valid_i = 1'b1; out_ready_i = 1'b0;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        checks++; if (s_pop !== 1'b1) begin failures++; $display("FAIL fl_pop_c1 got=%b exp=1", s_pop); end
        out_ready_i = 1'b1;
        tick();
        checks++; if (s_pop !== 1'b1 || s_valid !== 1'b1 || s_data !== 32'h20) begin
            failures++; $display("FAIL fl_c2 got=%b/%b/%h exp=1/1/00000020", s_pop, s_valid, s_data);
        end
        out_ready_i = 1'b0;
        tick();
        checks++; if (s_pop !== 1'b1) begin failures++; $display("FAIL fl_pop_c3 got=%b exp=1", s_pop); end
        flush_i = 1'b1;
        tick();
        checks++; if (s_pop !== 1'b0 || s_valid !== 1'b1 || s_data !== 32'h21) begin
            failures++; $display("FAIL fl_c4 got=%b/%b/%h exp=0/1/00000021", s_pop, s_valid, s_data);
        end
        flush_i = 1'b0;
        tick();
        checks++; if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_crdy !== 1'b1 || s_pop !== 1'b0) begin
            failures++; $display("FAIL fl_after got=%b/%b/%b/%b exp=0/0/1/0", s_valid, s_busy, s_crdy, s_pop);
        end
        // Flush in a cycle where a pop would otherwise fire.
        cmd_len_i = 8'd3; cmd_valid_i = 1'b1; out_ready_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        checks++; if (s_pop !== 1'b1) begin failures++; $display("FAIL fl2_pop_c1 got=%b exp=1", s_pop); end
        flush_i = 1'b1;
        tick();
        checks++; if (s_pop !== 1'b0) begin failures++; $display("FAIL fl2_pop_flush got=%b exp=0", s_pop); end
        flush_i = 1'b0;
        tick();
        checks++; if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
            failures++; $display("FAIL fl2_after got=%b/%b exp=0/0", s_valid, s_busy);
        end
        // FIFO now holds 0x24..0x27; a 2-beat burst takes exactly two.
        pops = 0; beats = 0;
        cmd_len_i = 8'd1; cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (s_pop === 1'b1) pops++;
            if (s_valid === 1'b1 && s_ready === 1'b1) begin
                checks++; if (s_data !== DW'(32'h24 + beats) || s_last !== (beats == 1)) begin
                    failures++; $display("FAIL fl3_beat n=%0d got=%h/%b exp=%h/%b", beats, s_data, s_last, 32'h24 + beats, beats == 1);
                end
                beats++;
            end
        end
        checks++; if (pops != 2) begin failures++; $display("FAIL fl3_pops got=%0d exp=2", pops); end
        checks++; if (beats != 2) begin failures++; $display("FAIL fl3_beats got=%0d exp=2", beats); end
        checks++; if (fq.size() != 2) begin failures++; $display("FAIL fl3_fifo_left got=%0d exp=2", fq.size()); end
        fq.delete(); drive_fifo();
    endtask

    initial begin
        test_reset();
        test_burst8();
        test_backpressure();
        test_empty_stall();
        test_max_burst();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule : tb_fifo_burst_reader

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side engine for a push/pop FIFO. It accepts a burst command of N beats and pops exactly N words from the FIFO's empty/pop/data port. It emits them on a valid/ready stream, flagging the final beat with `last`. It sits between a FIFO instance and a streaming consumer such as a DMA write channel or packetizer, and decouples consumer back-pressure from the FIFO pop strobe through a 2-entry output buffer.

## Interface
- DATA_WIDTH, 32, payload width when dtype is left at default
- dtype, logic [DATA_WIDTH-1:0], payload type
- LEN_WIDTH, 8, width of burst length field; max burst = 2**LEN_WIDTH beats

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  synchronous abort: drop the burst in flight and clear the buffer
- cmd_valid_i  in  1  burst command valid
- cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o
- cmd_len_i  in  LEN_WIDTH  beats minus one (0 = 1 beat)
- fifo_empty_i  in  1  FIFO empty flag
- fifo_data_i  in  dtype  FIFO head data
- fifo_pop_o  out  1  pop FIFO head this cycle
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  consumer ready
- out_data_o  out  dtype  output beat payload
- out_last_o  out  1  final beat of burst
- busy_o  out  1  burst in progress (state != IDLE)

## Operation
- FSM states: IDLE, BURST, DRAIN.
- IDLE:
  - cmd_ready_o = 1.
  - On command handshake, load `remaining_q <= cmd_len_i` and go to BURST.
- BURST:
  - fifo_pop_o = ~fifo_empty_i & (buf_cnt < 2).
  - fifo_pop_o never depends combinationally on out_ready_i.
  - Each pop writes {fifo_data_i, last = (remaining_q == 0)} into the buffer.
  - If remaining_q == 0 on a pop, go to DRAIN; otherwise decrement remaining_q.
- DRAIN:
  - No pops.
  - Go to IDLE in the cycle the last beat is accepted (out_valid_o & out_ready_i & out_last_o).
  - cmd_ready_o is 0 in BURST and DRAIN.
- Buffer:
  - 2-entry in-order queue; out_valid_o = (buf_cnt != 0).
  - Head drives out_data_o and out_last_o.
  - Simultaneous push and pop leaves buf_cnt unchanged.
- The beat counter is LEN_WIDTH bits, counts down, and never wraps: the transition to DRAIN happens at 0.
- Exactly cmd_len_i+1 pops occur per burst, never more, regardless of FIFO occupancy.
- fifo_empty_i = 1 stalls pops indefinitely with no timeout; out_valid_o drops when the buffer drains.
- flush_i, or rst_i:
  - Next state is IDLE; buf_cnt = 0 and remaining_q = 0.
  - fifo_pop_o is forced 0 in that cycle.
  - Data already popped is discarded.
  - rst_i has priority over flush_i.
- The consumer holds out_ready_i freely; out_data_o and out_last_o are stable while out_valid_o & ~out_ready_i.

## Timing
- Values during and after reset:
  - cmd_ready_o = 1 (IDLE)
  - busy_o = 0
  - fifo_pop_o = 0
  - out_valid_o = 0
  - out_last_o = 0
  - out_data_o = '0 (buffer storage reset)
- Latency:
  - Command accepted in cycle 0.
  - First pop possible in cycle 1.
  - First out_valid_o in cycle 2.
- Throughput: 1 beat/cycle sustained with fifo non-empty and out_ready_i held high.
- After the last beat is accepted in cycle t, cmd_ready_o = 1 in cycle t+1.
- Minimum burst-to-burst gap is one IDLE cycle.
- A 1-beat burst (cmd_len_i = 0) pops once in cycle 1 and enters DRAIN in cycle 2; out_last_o = 1 on that beat.

## Structure
- Package fifo_burst_pkg holds the state typedef `fifo_burst_state_e` {IDLE, BURST, DRAIN}, so the bench can reference it.
- No other shared constants.
- Sub-module: `burst_out_buffer`, a 2-entry valid/ready queue carrying {dtype, last}, with synchronous clear, push/pop ports and count output.
- The FSM and counter live in the top.

## Test plan
- Reset, then idle: cmd_ready_o = 1 and busy_o = fifo_pop_o = out_valid_o = 0 for 10 cycles with fifo_empty_i = 0.
- FIFO preloaded with 0x10..0x17, cmd_len_i = 7, out_ready_i = 1:
  - 8 pops in cycles 1–8.
  - Outputs 0x10..0x17 in cycles 2–9; out_last_o only on 0x17.
  - cmd_ready_o = 1 in cycle 10.
- Same burst with out_ready_i toggling 1,0,0,1:
  - Payload order preserved and no beat dropped or duplicated.
  - fifo_pop_o = 0 whenever buf_cnt = 2.
  - Exactly 8 pops total.
- cmd_len_i = 0 with fifo_empty_i = 1 for 5 cycles, then 0:
  - No pop and no out_valid_o while empty.
  - Single pop on the first non-empty cycle.
  - One beat with out_last_o = 1.
- cmd_len_i = 255 (max): exactly 256 pops; the counter does not wrap; out_last_o is on beat 256 only.
- flush_i asserted after 3 pops of a 6-beat burst, with 2 beats buffered:
  - Next cycle: out_valid_o = 0, busy_o = 0, cmd_ready_o = 1, and no pop in the flush cycle.
  - A new cmd_len_i = 1 then yields exactly 2 pops, the second with out_last_o = 1.
